// File: rtl/instr_prefetch_pkg.sv
// Shared defaults and sizing helpers for the instruction prefetch queue.
package instr_prefetch_pkg;

  localparam int PF_ADDR_W = 16;
  localparam int PF_DATA_W = 32;
  localparam int PF_DEPTH  = 4;

  // An occupancy counter must hold DEPTH itself, hence the extra bit.
  function automatic int pf_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO of {pc, word} entries with flush; head is read combinationally.
module instr_prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int WIDTH = PF_ADDR_W + PF_DATA_W,
  parameter int DEPTH = PF_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [WIDTH-1:0]              head_data,
  output logic [pf_cnt_w(DEPTH)-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = pf_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are never visible past count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = mem[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: issues sequential RAM reads and queues {pc, word} for the fetch controller.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W,
  parameter int DATA_W = PF_DATA_W,
  parameter int DEPTH  = PF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              hlt,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int CNT_W = pf_cnt_w(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_epoch_q, pend_epoch_d;
  logic              epoch_q, epoch_d;

  logic [CNT_W-1:0]         fifo_count;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [CNT_W:0]           in_use;
  logic                     issue, push, pop;

  // Credit counts the in-flight read so a response always has a free slot.
  assign in_use = {1'b0, fifo_count} + (CNT_W+1)'(pending_q);
  assign issue  = reset & ~hlt & ~redirect & (in_use < (CNT_W+1)'(DEPTH));
  assign push   = pending_q & (pend_epoch_q == epoch_q) & ~redirect;

  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign instr_pc    = instr_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
  assign instr_data  = instr_valid ? head[DATA_W-1:0] : '0;

  assign mem_rd   = issue;
  assign mem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_epoch_d = pend_epoch_q;
    pending_d    = issue;
    epoch_d      = epoch_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      epoch_d    = ~epoch_q;
    end else if (issue) begin
      fetch_pc_d   = fetch_pc_q + ADDR_W'(1);
      pend_pc_d    = fetch_pc_q;
      pend_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= '0;
      pending_q    <= 1'b0;
      pend_pc_q    <= '0;
      pend_epoch_q <= 1'b0;
      epoch_q      <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pend_pc_q    <= pend_pc_d;
      pend_epoch_q <= pend_epoch_d;
      epoch_q      <= epoch_d;
    end
  end

  instr_prefetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({pend_pc_q, mem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench: vector table, corner-case sequences and random traffic vs a queue model.
module tb_instr_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  instr_prefetch #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hlt         (hlt),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return 32'(a) * 32'h01010101;
  endfunction

  // Synchronous RAM: one-cycle read latency, garbage when not read.
  always @(posedge clk) mem_rdata <= mem_rd ? ram_word(mem_addr) : 32'hDEADBEEF;

  // Reference model: words visible to the consumer, the read in flight, next fetch pc.
  logic [15:0] mq[$];
  logic        inf_v;
  logic [15:0] inf_pc;
  logic [15:0] mpc;
  logic [15:0] last_pop_pc;

  typedef struct {
    logic        rd;
    logic [15:0] rpc;
    logic        h;
    logic        rdy;
    logic        e_mem_rd;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    inf_v  = 1'b0;
    inf_pc = '0;
    mpc    = '0;
  endtask

  task automatic cycle(input vec_t v, input bit tab);
    logic exp_rd;
    redirect    = v.rd;
    redirect_pc = v.rpc;
    hlt         = v.h;
    instr_ready = v.rdy;
    @(negedge clk);
    exp_rd = !v.h && !v.rd && ((mq.size() + int'(inf_v)) < DEPTH);
    chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
    chk("mem_addr", 32'(mem_addr), 32'(mpc));
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
    chk("instr_pc", 32'(instr_pc), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    chk("instr_data", instr_data, (mq.size() > 0) ? ram_word(mq[0]) : 32'd0);
    if (tab) begin
      chk("tab_mem_rd", 32'(mem_rd), 32'(v.e_mem_rd));
      chk("tab_mem_addr", 32'(mem_addr), 32'(v.e_addr));
      chk("tab_valid", 32'(instr_valid), 32'(v.e_valid));
      chk("tab_pc", 32'(instr_pc), 32'(v.e_pc));
      chk("tab_data", instr_data, v.e_data);
    end
    @(posedge clk);
    if (v.rd) begin
      $display("redirect to pc=%h", v.rpc);
      mq.delete();
      inf_v = 1'b0;
      mpc   = v.rpc;
    end else begin
      if (mq.size() > 0 && v.rdy) begin
        $display("pop pc=%h data=%h", mq[0], ram_word(mq[0]));
        last_pop_pc = mq.pop_front();
      end
      if (inf_v) mq.push_back(inf_pc);
      inf_v = exp_rd;
      if (exp_rd) begin
        inf_pc = mpc;
        mpc    = mpc + 16'd1;
      end
    end
    #1;
  endtask

  task automatic step(input logic rd, input logic [15:0] rpc, input logic h, input logic rdy);
    vec_t v;
    v = '{rd, rpc, h, rdy, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0};
    cycle(v, 1'b0);
  endtask

  initial begin
    vec_t tab [12];
    logic [15:0] saved_pc;

    // Startup stream, then back-pressure until full and a single pop.
    tab[0]  = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 32'h00000000};
    tab[1]  = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 32'h00000000};
    tab[2]  = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 32'h00000000};
    tab[3]  = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001, 32'h01010101};
    tab[4]  = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 32'h02020202};
    tab[5]  = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 16'h0003, 32'h03030303};
    tab[6]  = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h0003, 32'h03030303};
    tab[7]  = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b1, 16'h0003, 32'h03030303};
    tab[8]  = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b1, 16'h0003, 32'h03030303};
    tab[9]  = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0007, 1'b1, 16'h0003, 32'h03030303};
    tab[10] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 16'h0004, 32'h04040404};
    tab[11] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0004, 32'h04040404};

    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; hlt = 1'b0; instr_ready = 1'b1;
    last_pop_pc = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) cycle(tab[i], 1'b1);

    // Redirect while a read is in flight and three words are queued.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0100, 1'b0, 1'b1);
    chk("redir_flush", 32'(instr_valid), 32'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("redir_not_early", 32'(instr_valid), 32'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("redir_first_valid", 32'(instr_valid), 32'd1);
    chk("redir_first_pc", 32'(instr_pc), 32'h0100);

    // Fetch pc wraps from 0xFFFF to 0x0000.
    step(1'b1, 16'hFFFF, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("wrap_pc0", 32'(instr_pc), 32'hFFFF);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("wrap_pc1", 32'(instr_pc), 32'h0000);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("wrap_pc2", 32'(instr_pc), 32'h0001);

    // Halt mid-stream: in-flight word lands, queue drains, resume sequentially.
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 16'h0, 1'b1, 1'b1);
    chk("halt_drained", 32'(instr_valid), 32'd0);
    saved_pc = last_pop_pc;
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("halt_resume_valid", 32'(instr_valid), 32'd1);
    chk("halt_resume_pc", 32'(instr_pc), 32'(saved_pc + 16'd1));

    // Asynchronous reset between clock edges.
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_mem_rd", 32'(mem_rd), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_pc", 32'(instr_pc), 32'd0);
    chk("arst_data", instr_data, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("arst_restart_valid", 32'(instr_valid), 32'd1);
    chk("arst_restart_pc", 32'(instr_pc), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r_rd, r_h, r_rdy;
      logic [15:0] r_pc;
      r_rd  = ($urandom_range(0, 19) == 0);
      r_h   = ($urandom_range(0, 6) == 0);
      r_rdy = ($urandom_range(0, 9) < 6);
      r_pc  = ($urandom_range(0, 2) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2))
                                          : 16'($urandom);
      step(r_rd, r_pc, r_h, r_rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
